// File: rtl/rv_core_pkg.sv
// Core-wide constants and types shared by the register file and its scoreboard.
package rv_core_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned ZERO_REG_IDX = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy bits tracking outstanding late (load) writes.
module rf_scoreboard
    import rv_core_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;
    logic             set_ok;

    assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == AW'(ZERO_REG_IDX)));

    // Set is applied after clear so a reissued load to the same register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with execute/late write ports, optional write-through
// bypass on the operand ports, a busy scoreboard and an unbypassed debug read port.
module register_file_mp
    import rv_core_pkg::*;
#(
    parameter  int unsigned WIDTH    = XLEN,
    parameter  int unsigned NREGS    = 2 ** REG_AW,
    parameter  int unsigned NRD      = 2,
    parameter  int unsigned BYPASS   = 1,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [AW-1:0]        Destination_select,
    input  logic [WIDTH-1:0]     DATA,
    input  logic                 late_we,
    input  logic [AW-1:0]        late_addr,
    input  logic [WIDTH-1:0]     late_data,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    input  logic [NRD*AW-1:0]    Source_select,
    output logic [NRD*WIDTH-1:0] out,
    output logic [NRD-1:0]       out_busy,
    input  logic [AW-1:0]        Debug_Source_select,
    output logic [WIDTH-1:0]     Debug_out,
    output logic [NREGS-1:0]     busy_vec
);

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == AW'(ZERO_REG_IDX));
    endfunction

    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy;

    // Late write goes first so an execute write to the same register overrides it.
    always_comb begin
        regs_d = regs_q;
        if (late_we && !is_zero(late_addr)) begin
            regs_d[late_addr] = late_data;
        end
        if (write_enable && !is_zero(Destination_select)) begin
            regs_d[Destination_select] = DATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS   (NREGS),
        .AW      (AW),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .set_en  (busy_set),
        .set_addr(busy_addr),
        .clr_en  (late_we),
        .clr_addr(late_addr),
        .busy    (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] rd_data;
        logic             rd_busy;

        assign rd_addr = Source_select[k*AW +: AW];

        // Bypassed inputs are not yet reset-cleared, so gate the port while reset is held.
        always_comb begin
            rd_data = regs_q[rd_addr];
            rd_busy = busy[rd_addr];
            if (BYPASS != 0) begin
                if (late_we && (late_addr == rd_addr)) begin
                    rd_data = late_data;
                    rd_busy = 1'b0;
                end
                if (write_enable && (Destination_select == rd_addr)) begin
                    rd_data = DATA;
                end
            end
            if (is_zero(rd_addr) || !reset) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end

        assign out[k*WIDTH +: WIDTH] = rd_data;
        assign out_busy[k]           = rd_busy;
    end

    assign Debug_out = regs_q[Debug_Source_select];
    assign busy_vec  = busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised scoreboard bench for register_file_mp: bypassed and unbypassed copies share stimulus.
module tb_register_file_mp;

    localparam int unsigned W = 32;
    localparam int unsigned N = 32;
    localparam int unsigned R = 3;
    localparam int unsigned A = 5;

    logic           clk;
    logic           reset;
    logic           write_enable;
    logic [A-1:0]   Destination_select;
    logic [W-1:0]   DATA;
    logic           late_we;
    logic [A-1:0]   late_addr;
    logic [W-1:0]   late_data;
    logic           busy_set;
    logic [A-1:0]   busy_addr;
    logic [R*A-1:0] Source_select;
    logic [A-1:0]   Debug_Source_select;

    logic [R*W-1:0] out_b, out_n;
    logic [R-1:0]   ob_b, ob_n;
    logic [W-1:0]   dbg_b, dbg_n;
    logic [N-1:0]   bv_b, bv_n;

    register_file_mp #(.WIDTH(W), .NREGS(N), .NRD(R), .BYPASS(1), .ZERO_REG(1)) dut_byp (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .Destination_select(Destination_select), .DATA(DATA),
        .late_we(late_we), .late_addr(late_addr), .late_data(late_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .Source_select(Source_select),
        .out(out_b), .out_busy(ob_b), .Debug_Source_select(Debug_Source_select),
        .Debug_out(dbg_b), .busy_vec(bv_b)
    );

    register_file_mp #(.WIDTH(W), .NREGS(N), .NRD(R), .BYPASS(0), .ZERO_REG(1)) dut_nob (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .Destination_select(Destination_select), .DATA(DATA),
        .late_we(late_we), .late_addr(late_addr), .late_data(late_data),
        .busy_set(busy_set), .busy_addr(busy_addr), .Source_select(Source_select),
        .out(out_n), .out_busy(ob_n), .Debug_Source_select(Debug_Source_select),
        .Debug_out(dbg_n), .busy_vec(bv_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [R*W-1:0] out_b;
        logic [R-1:0]   busy_b;
        logic [R*W-1:0] out_n;
        logic [R-1:0]   busy_n;
        logic [W-1:0]   dbg;
        logic [N-1:0]   bv;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // Reference architectural state
    logic [W-1:0] m_regs [N];
    logic [N-1:0] m_busy;

    // Staged stimulus for the next cycle
    logic           s_rst, s_we, s_lwe, s_bs;
    logic [A-1:0]   s_d, s_la, s_ba, s_dbg;
    logic [W-1:0]   s_data, s_ld;
    logic [R*A-1:0] s_src;

    task automatic chk(input string name, input logic [R*W-1:0] act, input logic [R*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic [A-1:0] a;
        e.out_b = '0; e.busy_b = '0; e.out_n = '0; e.busy_n = '0;
        e.dbg = m_regs[s_dbg];
        e.bv  = m_busy;
        if (!s_rst) begin
            e.dbg = '0;
            e.bv  = '0;
            return e;
        end
        for (int unsigned k = 0; k < R; k++) begin
            a = s_src[k*A +: A];
            if (a != 0) begin
                e.out_n[k*W +: W] = m_regs[a];
                e.busy_n[k]       = m_busy[a];
                if (s_we && s_d == a) begin
                    e.out_b[k*W +: W] = s_data;
                    e.busy_b[k]       = m_busy[a] && !(s_lwe && s_la == a);
                end else if (s_lwe && s_la == a) begin
                    e.out_b[k*W +: W] = s_ld;
                    e.busy_b[k]       = 1'b0;
                end else begin
                    e.out_b[k*W +: W] = m_regs[a];
                    e.busy_b[k]       = m_busy[a];
                end
            end
        end
        return e;
    endfunction

    task automatic commit();
        if (s_lwe && s_la != 0) m_regs[s_la] = s_ld;
        if (s_we && s_d != 0)   m_regs[s_d]  = s_data;
        if (s_lwe)              m_busy[s_la] = 1'b0;
        if (s_bs && s_ba != 0)  m_busy[s_ba] = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        reset = s_rst; write_enable = s_we; Destination_select = s_d; DATA = s_data;
        late_we = s_lwe; late_addr = s_la; late_data = s_ld;
        busy_set = s_bs; busy_addr = s_ba; Source_select = s_src; Debug_Source_select = s_dbg;
        if (!s_rst) begin
            for (int unsigned i = 0; i < N; i++) m_regs[i] = '0;
            m_busy = '0;
        end
        q.push_back(predict());
        @(posedge clk);
        if (s_rst) commit();
    endtask

    task automatic set_idle();
        s_rst = 1'b1; s_we = 1'b0; s_lwe = 1'b0; s_bs = 1'b0;
        s_d = '0; s_la = '0; s_ba = '0; s_dbg = '0;
        s_data = '0; s_ld = '0; s_src = '0;
    endtask

    function automatic logic [A-1:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return A'($urandom_range(0, 3));
        return A'($urandom_range(0, N - 1));
    endfunction

    // Monitor: compares every presented cycle against the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_bypass",     out_b,                e.out_b);
                chk("busy_bypass",    (R*W)'(ob_b),         (R*W)'(e.busy_b));
                chk("out_nobypass",   out_n,                e.out_n);
                chk("busy_nobypass",  (R*W)'(ob_n),         (R*W)'(e.busy_n));
                chk("debug_out",      (R*W)'({dbg_n, dbg_b}), (R*W)'({e.dbg, e.dbg}));
                chk("busy_vec",       (R*W)'({bv_n, bv_b}),   (R*W)'({e.bv, e.bv}));
            end
        end
    end

    initial begin : driver
        int unsigned wait_cycles;
        reset = 1'b0; write_enable = 1'b0; Destination_select = '0; DATA = '0;
        late_we = 1'b0; late_addr = '0; late_data = '0; busy_set = 1'b0; busy_addr = '0;
        Source_select = '0; Debug_Source_select = '0;
        for (int unsigned i = 0; i < N; i++) m_regs[i] = '0;
        m_busy = '0;

        set_idle(); s_rst = 1'b0; step();
        set_idle(); step();

        // Reset asserted during an in-flight write
        set_idle(); s_we = 1'b1; s_d = 5'd5; s_data = 32'h1111; step();
        set_idle(); s_bs = 1'b1; s_ba = 5'd6; step();
        set_idle(); s_rst = 1'b0; s_we = 1'b1; s_d = 5'd5; s_data = 32'hDEAD;
        s_dbg = 5'd5; s_src = {5'd6, 5'd5, 5'd5}; step();
        #1;
        chk("reset_debug_reg5", (R*W)'(dbg_b), '0);
        chk("reset_busy_vec",   (R*W)'(bv_b),  '0);
        chk("reset_out",        out_b,         '0);
        set_idle(); step();

        // Write-through bypass vs stored-value read
        set_idle(); s_we = 1'b1; s_d = 5'd7; s_data = 32'hCAFE_F00D; step();
        set_idle(); s_we = 1'b1; s_d = 5'd7; s_data = 32'h1234_5678;
        s_src = {5'd0, 5'd0, 5'd7}; s_dbg = 5'd7; step();
        #1;
        chk("nobypass_next_cycle", (R*W)'(out_n[W-1:0]), (R*W)'(32'h1234_5678));
        chk("debug_after_write",   (R*W)'(dbg_b),        (R*W)'(32'h1234_5678));

        // Register zero
        set_idle(); s_we = 1'b1; s_d = 5'd0; s_data = 32'hFFFF_FFFF;
        s_bs = 1'b1; s_ba = 5'd0; step();
        #1;
        chk("zero_busy",  (R*W)'(bv_b[0]), '0);
        chk("zero_read",  out_b,           '0);
        chk("zero_debug", (R*W)'(dbg_b),   '0);

        // Execute/late collision
        set_idle(); s_bs = 1'b1; s_ba = 5'd9; step();
        set_idle(); s_we = 1'b1; s_d = 5'd9; s_data = 32'hAAAA;
        s_lwe = 1'b1; s_la = 5'd9; s_ld = 32'hBBBB; s_dbg = 5'd9; s_src = {3{5'd9}}; step();
        #1;
        chk("collision_data", (R*W)'(dbg_b),   (R*W)'(32'hAAAA));
        chk("collision_busy", (R*W)'(bv_b[9]), '0);

        // Scoreboard set / clear / set-wins
        set_idle(); s_bs = 1'b1; s_ba = 5'd3; s_src = {5'd1, 5'd2, 5'd3}; step();
        #1;
        chk("busy_after_set", (R*W)'(ob_b[0]), (R*W)'(1'b1));
        set_idle(); s_lwe = 1'b1; s_la = 5'd3; s_ld = 32'h55; s_src = {5'd1, 5'd2, 5'd3}; step();
        set_idle(); s_bs = 1'b1; s_ba = 5'd3; s_lwe = 1'b1; s_la = 5'd3; s_ld = 32'h77; step();
        #1;
        chk("set_wins_over_clear", (R*W)'(bv_b[3]), (R*W)'(1'b1));

        // Random multi-port traffic
        for (int unsigned n = 0; n < 2000; n++) begin
            s_rst  = ($urandom_range(0, 499) != 0);
            s_we   = 1'($urandom_range(0, 1));
            s_d    = rand_addr();
            s_data = $urandom;
            s_lwe  = 1'($urandom_range(0, 1));
            s_la   = rand_addr();
            s_ld   = $urandom;
            s_bs   = 1'($urandom_range(0, 1));
            s_ba   = rand_addr();
            s_src  = {rand_addr(), rand_addr(), rand_addr()};
            s_dbg  = rand_addr();
            step();
        end

        set_idle(); step();
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0", q.size());
        end
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
